// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO sweep sequencer.
// Triangle sweeps are compiled in with NCO_SWEEP_TRIANGLE_EN.
package nco_pkg;

  localparam int unsigned FW = 28;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDwell = 2'd1,
    StDone  = 2'd2
  } sweep_state_t;

  typedef struct packed {
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_step;
    logic [CW-1:0] n_steps;
    logic [CW-1:0] dwell;
    logic          phase_clr;
    logic          tri_en;
  } sweep_cfg_t;

  // A zero dwell would never expire, so it behaves as a single cycle.
  function automatic logic [CW-1:0] dwell_eff(input logic [CW-1:0] d);
    return (d == '0) ? CW'(1) : d;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable dwell down-counter; flags the last cycle of each dwell and
// reloads itself so consecutive dwells are back to back.
module dwell_timer
  import nco_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] dwell,
  input  logic          en,
  output logic          expired
);

  logic [CW-1:0] reload_q;
  logic [CW-1:0] cnt_q;

  always_comb begin
    expired = en && (cnt_q <= CW'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      reload_q <= dwell_eff(dwell);
      cnt_q    <= dwell_eff(dwell);
    end else if (en) begin
      cnt_q <= expired ? reload_q : cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-sweep sequencer feeding the NCO frequency word.
// Define NCO_SWEEP_TRIANGLE_EN to enable up/down (triangle) sweeps.
module nco_sweep_ctrl
  import nco_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [FW-1:0] cfg_f_start,
  input  logic [FW-1:0] cfg_f_step,
  input  logic [CW-1:0] cfg_n_steps,
  input  logic [CW-1:0] cfg_dwell,
  input  logic          cfg_phase_clr,
  input  logic          cfg_tri,
  input  logic          abort,
  output logic [FW-1:0] freq,
  output logic          nco_rst,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] step_idx
);

  sweep_cfg_t   cfg_in;
  sweep_state_t state_q, state_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [FW-1:0] step_q, step_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] nsteps_q, nsteps_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          nco_rst_q, nco_rst_d;
  logic          timer_load, timer_en, expired;
  logic          finish;

  assign cfg_in = '{
    f_start:   cfg_f_start,
    f_step:    cfg_f_step,
    n_steps:   cfg_n_steps,
    dwell:     cfg_dwell,
    phase_clr: cfg_phase_clr,
    tri_en:    cfg_tri
  };

`ifdef NCO_SWEEP_TRIANGLE_EN
  logic tri_q, tri_d;
  logic down_q, down_d;
`else
  logic unused_tri;
  assign unused_tri = cfg_in.tri_en;
`endif

  dwell_timer u_dwell_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .dwell   (cfg_in.dwell),
    .en      (timer_en),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    step_d     = step_q;
    idx_d      = idx_q;
    nsteps_d   = nsteps_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    nco_rst_d  = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    finish     = 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
    tri_d      = tri_q;
    down_d     = down_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          freq_d     = cfg_in.f_start;
          step_d     = cfg_in.f_step;
          nsteps_d   = cfg_in.n_steps;
          idx_d      = '0;
          busy_d     = 1'b1;
          nco_rst_d  = cfg_in.phase_clr;
          timer_load = 1'b1;
          state_d    = StDwell;
`ifdef NCO_SWEEP_TRIANGLE_EN
          tri_d      = cfg_in.tri_en;
          down_d     = 1'b0;
`endif
        end
      end
      StDwell: begin
        timer_en = 1'b1;
        // Abort takes priority over a coincident dwell expiry.
        if (abort) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (expired) begin
`ifdef NCO_SWEEP_TRIANGLE_EN
          if (!down_q) begin
            if (idx_q < nsteps_q) begin
              freq_d = freq_q + step_q;
              idx_d  = idx_q + CW'(1);
            end else if (tri_q && (nsteps_q != '0)) begin
              down_d = 1'b1;
              freq_d = freq_q - step_q;
              idx_d  = idx_q - CW'(1);
            end else begin
              finish = 1'b1;
            end
          end else if (idx_q != '0) begin
            freq_d = freq_q - step_q;
            idx_d  = idx_q - CW'(1);
          end else begin
            finish = 1'b1;
          end
`else
          if (idx_q < nsteps_q) begin
            freq_d = freq_q + step_q;
            idx_d  = idx_q + CW'(1);
          end else begin
            finish = 1'b1;
          end
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    if (finish) begin
      state_d = StDone;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      freq_q    <= '0;
      step_q    <= '0;
      idx_q     <= '0;
      nsteps_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nco_rst_q <= 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
      tri_q     <= 1'b0;
      down_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      freq_q    <= freq_d;
      step_q    <= step_d;
      idx_q     <= idx_d;
      nsteps_q  <= nsteps_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nco_rst_q <= nco_rst_d;
`ifdef NCO_SWEEP_TRIANGLE_EN
      tri_q     <= tri_d;
      down_q    <= down_d;
`endif
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign freq      = freq_q;
  assign step_idx  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign nco_rst   = nco_rst_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed self-checking bench for nco_sweep_ctrl.
module tb_nco_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [27:0] cfg_f_start;
  logic [27:0] cfg_f_step;
  logic [15:0] cfg_n_steps;
  logic [15:0] cfg_dwell;
  logic        cfg_phase_clr;
  logic        cfg_tri;
  logic        abort;
  logic [27:0] freq;
  logic        nco_rst;
  logic        busy;
  logic        done;
  logic [15:0] step_idx;

  int checks = 0;
  int failures = 0;

`ifdef NCO_SWEEP_TRIANGLE_EN
  localparam int TriDwells = 5;
`else
  localparam int TriDwells = 3;
`endif

  nco_sweep_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_f_start   (cfg_f_start),
    .cfg_f_step    (cfg_f_step),
    .cfg_n_steps   (cfg_n_steps),
    .cfg_dwell     (cfg_dwell),
    .cfg_phase_clr (cfg_phase_clr),
    .cfg_tri       (cfg_tri),
    .abort         (abort),
    .freq          (freq),
    .nco_rst       (nco_rst),
    .busy          (busy),
    .done          (done),
    .step_idx      (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [27:0] fs, input logic [27:0] st, input logic [15:0] n,
                         input logic [15:0] d, input logic pc, input logic tr);
    cfg_f_start   = fs;
    cfg_f_step    = st;
    cfg_n_steps   = n;
    cfg_dwell     = d;
    cfg_phase_clr = pc;
    cfg_tri       = tr;
  endtask

  initial begin
    rst = 1'b0;
    cfg_valid = 1'b0;
    abort = 1'b0;
    set_cfg(28'h0, 28'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_freq", 32'(freq), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_nco_rst", 32'(nco_rst), 32'h0);
    chk("rst_idx", 32'(step_idx), 32'h0);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", 32'(cfg_ready), 32'h1);
    chk("post_rst_freq", 32'(freq), 32'h0);

    // Basic sweep with phase clear.
    set_cfg(28'h100000, 28'h010000, 16'd3, 16'd4, 1'b1, 1'b0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("basic_ready_low", 32'(cfg_ready), 32'h0);
    for (int c = 0; c < 16; c++) begin
      chk("basic_freq", 32'(freq), 32'h100000 + 32'((c / 4) * 32'h10000));
      chk("basic_idx", 32'(step_idx), 32'(c / 4));
      chk("basic_busy", 32'(busy), 32'h1);
      chk("basic_done", 32'(done), 32'h0);
      chk("basic_nco_rst", 32'(nco_rst), (c == 0) ? 32'h1 : 32'h0);
      tick();
    end
    chk("basic_end_busy", 32'(busy), 32'h0);
    chk("basic_end_done", 32'(done), 32'h1);
    chk("basic_end_ready", 32'(cfg_ready), 32'h0);
    chk("basic_end_freq", 32'(freq), 32'h130000);
    tick();
    chk("basic_after_done", 32'(done), 32'h0);
    chk("basic_after_ready", 32'(cfg_ready), 32'h1);
    chk("basic_hold_freq", 32'(freq), 32'h130000);

    // N=0, D=0: one-cycle dwell, no phase clear.
    set_cfg(28'h0ABCDEF, 28'h1234, 16'd0, 16'd0, 1'b0, 1'b0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("n0_freq", 32'(freq), 32'h0ABCDEF);
    chk("n0_busy", 32'(busy), 32'h1);
    chk("n0_nco_rst", 32'(nco_rst), 32'h0);
    tick();
    chk("n0_done", 32'(done), 32'h1);
    chk("n0_busy_low", 32'(busy), 32'h0);
    tick();
    chk("n0_done_once", 32'(done), 32'h0);

    // Negative step wraps below zero.
    set_cfg(28'h0, 28'hFFFFFFF, 16'd2, 16'd1, 1'b0, 1'b0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("neg_freq0", 32'(freq), 32'h0);
    tick();
    chk("neg_freq1", 32'(freq), 32'hFFFFFFF);
    chk("neg_idx1", 32'(step_idx), 32'h1);
    tick();
    chk("neg_freq2", 32'(freq), 32'hFFFFFFE);
    tick();
    chk("neg_done", 32'(done), 32'h1);
    tick();

    // Abort at cycle 5 with cfg_valid held; descriptor changes after accept.
    set_cfg(28'h100000, 28'h010000, 16'd3, 16'd4, 1'b0, 1'b0);
    cfg_valid = 1'b1;
    tick();
    cfg_f_start = 28'h200000;
    for (int c = 1; c < 5; c++) begin
      chk("abort_ready_low", 32'(cfg_ready), 32'h0);
      tick();
    end
    chk("abort_c5_freq", 32'(freq), 32'h110000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_freq", 32'(freq), 32'h110000);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_ready", 32'(cfg_ready), 32'h1);
    tick();
    cfg_valid = 1'b0;
    chk("reaccept_busy", 32'(busy), 32'h1);
    chk("reaccept_freq", 32'(freq), 32'h200000);
    abort = 1'b1;
    tick();
    chk("abort2_idle", 32'(cfg_ready), 32'h1);
    tick();
    chk("abort_idle_noeffect", 32'(cfg_ready), 32'h1);
    abort = 1'b0;

    // Triangle descriptor; single direction unless the macro is defined.
    set_cfg(28'h0, 28'h10, 16'd2, 16'd2, 1'b0, 1'b1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int j = 0; j < TriDwells; j++) begin
      for (int k = 0; k < 2; k++) begin
        chk("tri_freq", 32'(freq), (j <= 2) ? 32'(j * 16) : 32'((4 - j) * 16));
        chk("tri_idx", 32'(step_idx), (j <= 2) ? 32'(j) : 32'(4 - j));
        chk("tri_busy", 32'(busy), 32'h1);
        tick();
      end
    end
    chk("tri_done", 32'(done), 32'h1);
    tick();

    // Asynchronous reset mid-sweep.
    set_cfg(28'h0555555, 28'h1, 16'd5, 16'd3, 1'b1, 1'b0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_freq_pre", 32'(freq), 32'h0555556);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_freq", 32'(freq), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_idx", 32'(step_idx), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_nco", 32'(nco_rst), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rel_ready", 32'(cfg_ready), 32'h1);
    chk("mid_rel_freq", 32'(freq), 32'h0);
    chk("mid_rel_done", 32'(done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
